// File: rtl/dmem_arbiter_if.sv
// Data-memory arbiter bus bundle.
// Requester ports plus the data_mem side.
`timescale 1ns/1ps
interface dmem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              p0_req;
  logic              p0_we;
  logic [ADDR_W-1:0] p0_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic              p0_gnt;
  logic              p0_rvalid;
  logic [DATA_W-1:0] p0_rdata;

  logic              p1_req;
  logic              p1_we;
  logic [ADDR_W-1:0] p1_addr;
  logic [DATA_W-1:0] p1_wdata;
  logic              p1_gnt;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p1_rdata;

  logic              mem_r_enable;
  logic              mem_w_enable;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_re_data;

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_rvalid, p1_rdata,
    output mem_r_enable, mem_w_enable,
    output mem_address, mem_wr_data,
    input  mem_re_data
  );

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  mem_r_enable, mem_w_enable,
    input  mem_address, mem_wr_data,
    output mem_re_data
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: MEM stage first,
// loader second, with a starvation guard for the loader.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus
);

  localparam logic [0:0] ST_NORMAL  = 1'b0;
  localparam logic [0:0] ST_P1_PRIO = 1'b1;
  localparam logic [3:0] MAX_CNT    = 4'(MAX_WAIT);
  localparam logic [3:0] CNT_SAT    = 4'hF;

  logic [0:0]        r_state;
  logic [0:0]        w_state_nxt;
  logic [3:0]        r_wait_cnt;
  logic [3:0]        w_wait_nxt;
  logic              r_rd_pend;
  logic              r_rd_owner;

  logic              w_p1_first;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_deny1;
  logic              w_we;
  logic              w_re_en;
  logic              w_we_en;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;

  // Priority grant; reset masks every grant.
  always_comb begin
    w_p1_first = (r_state == ST_P1_PRIO);
    w_gnt0 = rst_n & bus.p0_req
           & ~(w_p1_first & bus.p1_req);
    w_gnt1 = rst_n & bus.p1_req
           & ~(~w_p1_first & bus.p0_req);
  end

  // Route the granted port onto the memory bus.
  always_comb begin
    w_we    = bus.p0_we;
    w_addr  = bus.p0_addr;
    w_wdata = bus.p0_wdata;
    unique case (1'b1)
      w_gnt1: begin
        w_we    = bus.p1_we;
        w_addr  = bus.p1_addr;
        w_wdata = bus.p1_wdata;
      end
      default: begin
        w_we    = bus.p0_we;
        w_addr  = bus.p0_addr;
        w_wdata = bus.p0_wdata;
      end
    endcase
    w_re_en = (w_gnt0 | w_gnt1) & ~w_we;
    w_we_en = (w_gnt0 | w_gnt1) & w_we;
  end

  // Loader denial counter, saturating at 15.
  always_comb begin
    w_deny1 = bus.p1_req & ~w_gnt1;
    w_wait_nxt = r_wait_cnt;
    if (!w_deny1)
      w_wait_nxt = '0;
    else if (r_wait_cnt != CNT_SAT)
      w_wait_nxt = r_wait_cnt + 4'd1;
  end

  // Starvation FSM next state.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_NORMAL: begin
        if (w_deny1 && (w_wait_nxt >= MAX_CNT))
          w_state_nxt = ST_P1_PRIO;
      end
      ST_P1_PRIO: begin
        if (w_gnt1 || !bus.p1_req)
          w_state_nxt = ST_NORMAL;
      end
      default: w_state_nxt = ST_NORMAL;
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_NORMAL;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Remember who owns the read in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_rd_pend  <= w_re_en;
      r_rd_owner <= w_gnt1;
    end
  end

  assign bus.p0_gnt       = w_gnt0;
  assign bus.p1_gnt       = w_gnt1;
  assign bus.mem_r_enable = w_re_en;
  assign bus.mem_w_enable = w_we_en;
  assign bus.mem_address  = w_addr;
  assign bus.mem_wr_data  = w_wdata;
  assign bus.p0_rvalid    = r_rd_pend & ~r_rd_owner;
  assign bus.p1_rvalid    = r_rd_pend & r_rd_owner;
  assign bus.p0_rdata     = bus.mem_re_data;
  assign bus.p1_rdata     = bus.mem_re_data;

endmodule
